mtimer: RTL

MTIMER -- requirements
Module: mtimer

---
 rtl/mtimer_if.sv | 29 ++
 rtl/mtimer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mtimer_if.sv
// mtimer_if: bus bundle between a core-side master and the mtimer register block.
//   we_i       write strobe, one write per cycle it is high
//   addr_i     byte address, only [3:2] are decoded by the timer
//   data_i     write data
//   data_o     read data, combinational from addr_i
//   int_flag_o interrupt vector towards the core interrupt arbiter
interface mtimer_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [7:0]  int_flag_o;

    modport master (
        output we_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  int_flag_o
    );

    modport slave (
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output int_flag_o
    );
endinterface

// File: rtl/mtimer.sv
// mtimer: memory-mapped prescaled compare timer with one-shot/periodic modes.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      mtimer_if.slave: we_i/addr_i/data_i in, data_o/int_flag_o out
// Register map (addr_i[3:2]): 0 CTRL {RELOAD,PEND,IE,EN}, 1 COUNT, 2 CMP, 3 PRESC.
module mtimer #(
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF,
    parameter int unsigned INT_BIT = 0
) (
    input  logic     clk,
    input  logic     rst,
    mtimer_if.slave  bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 8;
    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_COUNT = 2'd1;
    localparam logic [1:0] SEL_CMP   = 2'd2;
    localparam logic [1:0] SEL_PRESC = 2'd3;

    logic          en_q, en_d;
    logic          ie_q, ie_d;
    logic          pend_q, pend_d;
    logic          reload_q, reload_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] cmp_q, cmp_d;
    logic [DW-1:0] presc_q, presc_d;
    logic [DW-1:0] pcnt_q, pcnt_d;
    logic [IW-1:0] int_flag_q, int_flag_d;

    logic [1:0] sel;
    logic       wr_ctrl, wr_count, wr_cmp, wr_presc;
    logic       tick, match;
    logic       unused_addr_bits;

    assign sel              = bus.addr_i[3:2];
    assign unused_addr_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

    // Write decode
    assign wr_ctrl  = bus.we_i && (sel == SEL_CTRL);
    assign wr_count = bus.we_i && (sel == SEL_COUNT);
    assign wr_cmp   = bus.we_i && (sel == SEL_CMP);
    assign wr_presc = bus.we_i && (sel == SEL_PRESC);

    // A bus write to COUNT suppresses the compare for that cycle
    assign tick  = en_q && (pcnt_q == presc_q);
    assign match = tick && !wr_count && (count_q == cmp_q);

    // Next-state logic; later assignments express priority
    always_comb begin
        en_d       = en_q;
        ie_d       = ie_q;
        pend_d     = pend_q;
        reload_d   = reload_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        int_flag_d = '0;

        // Prescaler: held at 0 when disabled, wraps on tick
        if (!en_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + DW'(1);
        end
        if (wr_count || wr_presc) begin
            pcnt_d = '0;
        end

        if (tick) begin
            count_d = count_q + DW'(1);
        end
        if (match) begin
            count_d = '0;
            if (!reload_q) begin
                en_d = 1'b0;
            end
        end
        if (wr_count) begin
            count_d = bus.data_i;
        end

        // PEND: write-1-to-clear, but a concurrent match wins
        if (wr_ctrl && bus.data_i[2]) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end

        if (wr_ctrl) begin
            en_d     = bus.data_i[0];
            ie_d     = bus.data_i[1];
            reload_d = bus.data_i[3];
        end
        if (wr_cmp) begin
            cmp_d = bus.data_i;
        end
        if (wr_presc) begin
            presc_d = bus.data_i;
        end

        // Registered interrupt level tracks the next PEND & IE
        int_flag_d = IW'({{(IW-1){1'b0}}, pend_d & ie_d}) << INT_BIT;
    end

    // Read mux, no wait states
    always_comb begin
        bus.data_o = '0;
        case (sel)
            SEL_CTRL:  bus.data_o = {28'd0, reload_q, pend_q, ie_q, en_q};
            SEL_COUNT: bus.data_o = count_q;
            SEL_CMP:   bus.data_o = cmp_q;
            SEL_PRESC: bus.data_o = presc_q;
            default:   bus.data_o = '0;
        endcase
    end

    assign bus.int_flag_o = int_flag_q;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            pend_q     <= 1'b0;
            reload_q   <= 1'b0;
            count_q    <= '0;
            cmp_q      <= CMP_RST;
            presc_q    <= '0;
            pcnt_q     <= '0;
            int_flag_q <= '0;
        end else begin
            en_q       <= en_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            int_flag_q <= int_flag_d;
        end
    end
endmodule
